// File: rtl/turbo_pkg.sv
// Shared types and constants for the framed turbo encoder: FSM states,
// RSC generator polynomials and the bit layout of an output symbol.
package turbo_pkg;

  typedef enum logic [1:0] {LOAD, ENC, TAIL1, TAIL2} state_t;

  // Octal 13 / 15. Bit 3 is the D^0 coefficient, bit 0 is the D^3 coefficient.
  localparam logic [3:0] G0 = 4'b1011;
  localparam logic [3:0] G1 = 4'b1101;

  localparam int MEM      = 3;
  localparam int TAIL_LEN = 3;

  localparam int SYS = 2;
  localparam int P1  = 1;
  localparam int P2  = 0;

  function automatic int gcd(input int a, input int b);
    int x;
    int y;
    int t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

endpackage

// File: rtl/turbo_enc_frame_rsc.sv
// 8-state recursive systematic convolutional encoder (13/15 octal).
// With term high the input is replaced by the feedback, forcing the register toward zero.
module rsc_enc8
  import turbo_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic           term,
  input  logic           u,
  output logic           sys_out,
  output logic           par_out,
  output logic [MEM-1:0] state
);

  logic fb;
  logic a;

  // state[0] holds the newest bit, i.e. the D^1 tap.
  assign fb      = (state[0] & G0[2]) ^ (state[1] & G0[1]) ^ (state[2] & G0[0]);
  assign sys_out = term ? fb : u;
  assign a       = sys_out ^ fb;
  assign par_out = (a & G1[3]) ^ (state[0] & G1[2]) ^ (state[1] & G1[1]) ^ (state[2] & G1[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
    end else if (clr) begin
      state <= '0;
    end else if (en) begin
      state <= {state[1], state[0], a};
    end
  end

endmodule

// File: rtl/turbo_enc_frame.sv
// Framed turbo encoder: buffers a K-bit frame, then streams {sys, p1, p2}
// symbols from two RSC encoders (second one fed through pi(i) = P*i mod K), plus tails.
module turbo_enc_frame
  import turbo_pkg::*;
#(
  parameter int K         = 16,
  parameter int P         = 5,
  parameter int TERMINATE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
);

  localparam int CW  = $clog2(K);
  localparam int CW1 = CW + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);
  localparam logic [CW:0]   P_STEP   = CW1'(P % K);
  localparam logic [CW:0]   K_W      = CW1'(K);
  localparam logic [1:0]    TAIL_END = 2'(TAIL_LEN - 1);

  generate
    if (K < 4) begin : g_bad_k
      $error("turbo_enc_frame: K must be at least 4");
    end
    if (gcd(P, K) != 1) begin : g_bad_p
      $error("turbo_enc_frame: P and K must be coprime");
    end
  endgenerate

  state_t         state;
  logic [K-1:0]   frame_buf;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  idx2;
  logic [CW-1:0]  idx2_next;
  logic [CW:0]    idx2_sum;
  logic [1:0]     tcnt;

  logic           load_acc;
  logic           load_done;
  logic           step_en;
  logic           advance;
  logic           en1;
  logic           en2;
  logic           sys1;
  logic           par1;
  logic           sys2;
  logic           par2;
  logic [MEM-1:0] s1;
  logic [MEM-1:0] s2;
  logic [2:0]     sym;

  assign in_ready  = (state == LOAD);
  assign busy      = (state != LOAD);
  assign load_acc  = in_ready && in_valid;
  assign load_done = load_acc && (cnt == LAST_IDX);

  // A step happens when the output register is empty or being drained; a
  // presented out_last means the frame is done and only the hand-back to LOAD remains.
  assign step_en = !out_valid || out_ready;
  assign advance = busy && step_en && !out_last;
  assign en1     = advance && (state == ENC || state == TAIL1);
  assign en2     = advance && (state == ENC || state == TAIL2);

  assign idx2_sum  = {1'b0, idx2} + P_STEP;
  assign idx2_next = (idx2_sum >= K_W) ? CW'(idx2_sum - K_W) : CW'(idx2_sum);

  rsc_enc8 u_enc1 (
    .clk     (clk),
    .rst     (rst),
    .clr     (load_done),
    .en      (en1),
    .term    (state == TAIL1),
    .u       (frame_buf[cnt]),
    .sys_out (sys1),
    .par_out (par1),
    .state   (s1)
  );

  rsc_enc8 u_enc2 (
    .clk     (clk),
    .rst     (rst),
    .clr     (load_done),
    .en      (en2),
    .term    (state == TAIL2),
    .u       (frame_buf[idx2]),
    .sys_out (sys2),
    .par_out (par2),
    .state   (s2)
  );

  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    sym = '0;
    unique case (state)
      ENC: begin
        sym[SYS] = sys1;
        sym[P1]  = par1;
        sym[P2]  = par2;
      end
      TAIL1: begin
        sym[SYS] = sys1;
        sym[P1]  = par1;
      end
      TAIL2: begin
        sym[SYS] = sys2;
        sym[P2]  = par2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      // NOTE: the frame buffer is a plain register vector, so clearing it on reset is cheap and intended.
      frame_buf <= '0;
      cnt       <= '0;
      idx2      <= '0;
      tcnt      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (load_acc) begin
            frame_buf[cnt] <= in_bit;
            if (load_done) begin
              state <= ENC;
              cnt   <= '0;
              idx2  <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          if (step_en) begin
            if (out_last) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_valid <= 1'b1;
              out_data  <= sym;
              unique case (state)
                ENC: begin
                  idx2 <= idx2_next;
                  if (cnt == LAST_IDX) begin
                    cnt <= '0;
                    if (TERMINATE != 0) begin
                      state <= TAIL1;
                      tcnt  <= '0;
                    end else begin
                      out_last <= 1'b1;
                    end
                  end else begin
                    cnt <= cnt + 1'b1;
                  end
                end
                TAIL1: begin
                  if (tcnt == TAIL_END) begin
                    state <= TAIL2;
                    tcnt  <= '0;
                  end else begin
                    tcnt <= tcnt + 1'b1;
                  end
                end
                TAIL2: begin
                  if (tcnt == TAIL_END) begin
                    out_last <= 1'b1;
                    tcnt     <= '0;
                  end else begin
                    tcnt <= tcnt + 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
